cpuf_core_p: RTL and testbench
==============================

// Module: cpuf_core_p
// PURPOSE
//  Parametrised successor CPU core: PC, IR, A/B registers, ALU, accumulator and a multi-cycle sequencer.
//  Talks to an external memory over a req/ack handshake instead of an embedded RAM.
//  Adds conditional jumps (JZ/JC), Z/C flags and a run gate. Sits between the system memory and debug/top level.
// PARAMETERS
//  ADDR_W  4  address width; PC, operand and mem_addr width
//  DATA_W  8  data/instruction width; opcode = instr[DATA_W-1 -: 4], operand = instr[ADDR_W-1:0]; DATA_W >= ADDR_W+4
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  run        in   1       gates start of each new fetch
//  mem_req    out  1       memory request
//  mem_we     out  1       1 = write (WRT), 0 = read
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  DATA_W  write data (= ACC)
//  mem_rdata  in   DATA_W  read data, valid in cycle of mem_ack
//  mem_ack    in   1       transfer completes on edge where mem_req && mem_ack
//  acc_out    out  DATA_W  accumulator
//  pc_out     out  ADDR_W  program counter
//  flag_z     out  1       zero flag
//  flag_c     out  1       carry/borrow flag
//  halted     out  1       high in HALT state
// BEHAVIOUR
//  - Reset: state=FETCH, PC/IR/A/B/ACC=0, flag_z=flag_c=0, mem_req=mem_we=0, halted=0; overrides everything incl. a pending transfer.
//  - Opcodes: LDA 1000, LDB 0100, ADD 0010, SUB 0001, JMP 1001, JZ 1011, JC 1100, WRT 1010, HLT 1111.
//    All others, including 0000, are NOP.
//  - FETCH: if run, mem_req=1, mem_we=0, mem_addr=PC. On ack: IR<=mem_rdata, PC<=PC+1 (mod 2^ADDR_W), go to DECODE.
//    If run=0: mem_req=0 and the core stays in FETCH.
//  - DECODE (1 cycle):
//    * HLT -> HALT.
//    * JMP: PC<=operand.
//    * JZ: PC<=operand if flag_z. JC: PC<=operand if flag_c.
//    * ADD: {C,ACC}<=A+B (DATA_W+1 bits); Z<=(sum[DATA_W-1:0]==0).
//    * SUB: ACC<=A-B mod 2^DATA_W; C<=(A<B) borrow; Z<=(A==B).
//    * Jump, ALU and NOP opcodes -> FETCH.
//    * LDA/LDB/WRT -> MEM.
//  - MEM: mem_req=1, mem_addr=operand, mem_we=(op==WRT), mem_wdata=ACC. On ack: LDA A<=rdata, LDB B<=rdata; -> FETCH.
//  - Handshake: mem_req/we/addr/wdata held stable until the ack edge; mem_req drops the cycle after ack
//    unless the next state also requests. mem_ack without mem_req is ignored. Ack may be combinational (same cycle).
//  - Latency with ack tied high: each instruction = FETCH+DECODE = 2 cycles; LDA/LDB/WRT = 3 cycles.
//    Each wait cycle on ack adds 1.
//  - run only gates FETCH entry; an instruction in DECODE/MEM always completes.
//  - Flags change only on ADD/SUB; loads, jumps and WRT preserve them.
//  - HALT: terminal, halted=1, mem_req=0, all registers frozen; only reset exits.
//  - PC wrap: PC at 2^ADDR_W-1 increments to 0. Jump target equal to the current PC is legal (tight loop).
// TESTING
//  1. Reset mid-fetch (req high, ack low) -> next cycle mem_req=0, pc_out=0, acc_out=0, flags 0, halted=0.
//  2. mem[0]=LDA 6, [1]=LDB 7, [2]=ADD, [3]=WRT 8, [4]=HLT, [6]=0x05, [7]=0x03, ack=1
//     -> mem[8]=0x08, halted after 13 cycles, Z=0, C=0.
//  3. A=0xFF, B=0x01 ADD -> ACC=0x00, C=1, Z=1; following JZ 9 -> pc_out=9; JC 9 also taken.
//  4. A=0x02, B=0x05 SUB -> ACC=0xFD, C=1, Z=0; A=B=0x04 SUB -> ACC=0, Z=1, C=0; JZ not taken when Z=0 -> PC+1.
//  5. Ack delayed 3 cycles on fetch and on WRT -> mem_req/addr/wdata/we stable throughout, exactly one transfer each.
//  6. run=0 in DECODE of a LDA -> LDA completes, core then idles in FETCH with mem_req=0.
//     NOP at address 15 -> PC wraps to 0.

Source files
------------

// File: rtl/cpuf_core_p.sv
// Multi-cycle accumulator CPU core with PC/IR/A/B/ACC, Z/C flags and a run gate.
// Instructions and data come from external memory over a req/ack handshake.
module cpuf_core_p #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_JZ  = 4'b1011;
    localparam logic [3:0] OP_JC  = 4'b1100;
    localparam logic [3:0] OP_WRT = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic                z_q, z_d, c_q, c_d;
    logic                fact_q, fact_d;
    logic                req, we;
    logic [ADDR_W-1:0]   addr;
    logic [3:0]          op;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;

    assign op      = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = a_q - b_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        fact_d  = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        addr    = pc_q;
        case (state_q)
            S_FETCH: begin
                // Once a fetch has been issued it is held until acked, even if run drops.
                if (run || fact_q) begin
                    req = 1'b1;
                    if (mem_ack) begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_DECODE;
                    end else begin
                        fact_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (op)
                    OP_HLT: state_d = S_HALT;
                    OP_JMP: pc_d = operand;
                    OP_JZ:  if (z_q) pc_d = operand;
                    OP_JC:  if (c_q) pc_d = operand;
                    OP_ADD: begin
                        acc_d = sum[DATA_W-1:0];
                        c_d   = sum[DATA_W];
                        z_d   = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc_d = diff;
                        c_d   = (a_q < b_q);
                        z_d   = (a_q == b_q);
                    end
                    OP_LDA, OP_LDB, OP_WRT: state_d = S_MEM;
                    default: ;
                endcase
            end
            S_MEM: begin
                req  = 1'b1;
                addr = operand;
                we   = (op == OP_WRT);
                if (mem_ack) begin
                    if (op == OP_LDA) a_d = mem_rdata;
                    if (op == OP_LDB) b_d = mem_rdata;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            fact_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
            fact_q  <= fact_d;
        end
    end

    // Reset masks the request immediately so a pending transfer cannot complete.
    assign mem_req   = req && !reset;
    assign mem_we    = we && !reset;
    assign mem_addr  = addr;
    assign mem_wdata = acc_q;
    assign acc_out   = acc_q;
    assign pc_out    = pc_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpuf_core_p.sv
// Directed bench for cpuf_core_p: table of small programs run to HALT, plus
// hand sequences for reset mid-fetch, run gating and handshake stability.
module tb_cpuf_core_p;

    logic       clk = 1'b0;
    logic       reset, run;
    logic       mem_req, mem_we, mem_ack;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] acc_out;
    logic [3:0] pc_out;
    logic       flag_z, flag_c, halted;

    cpuf_core_p #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .acc_out(acc_out), .pc_out(pc_out), .flag_z(flag_z), .flag_c(flag_c),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: ack after dly wait cycles of an outstanding request.
    logic [7:0] mem [16];
    int dly = 0;
    int wcnt = 0;
    int xfers = 0;
    int wrs = 0;
    assign mem_ack   = mem_req && (wcnt >= dly);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (reset) begin
            wcnt  <= 0;
            xfers <= 0;
            wrs   <= 0;
        end else if (mem_req && mem_ack) begin
            wcnt  <= 0;
            xfers <= xfers + 1;
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wrs <= wrs + 1;
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Request must hold address/direction/data steady while waiting for ack.
    logic       stall_p = 1'b0;
    logic [3:0] s_addr;
    logic       s_we;
    logic [7:0] s_wd;
    always @(negedge clk) begin
        if (!reset && stall_p) begin
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_addr", {28'd0, mem_addr}, {28'd0, s_addr});
            chk("hold_we", {31'd0, mem_we}, {31'd0, s_we});
            if (s_we) chk("hold_wdata", {24'd0, mem_wdata}, {24'd0, s_wd});
        end
        stall_p = !reset && mem_req && !mem_ack;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wd    = mem_wdata;
    end

    typedef struct {
        logic [7:0] prog [16];
        int         dly;
        int         cyc;
        logic [7:0] acc;
        logic [3:0] pc;
        logic       z;
        logic       c;
        logic [3:0] ca;
        logic [7:0] cm;
        int         xf;
        int         wr;
    } vec_t;

    vec_t v [7];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input int i);
        int cyc;
        for (int k = 0; k < 16; k++) mem[k] = v[i].prog[k];
        dly = v[i].dly;
        do_reset();
        run_to_halt(cyc);
        chk($sformatf("v%0d_halted", i), {31'd0, halted}, 32'd1);
        chk($sformatf("v%0d_cycles", i), cyc, v[i].cyc);
        chk($sformatf("v%0d_acc", i), {24'd0, acc_out}, {24'd0, v[i].acc});
        chk($sformatf("v%0d_pc", i), {28'd0, pc_out}, {28'd0, v[i].pc});
        chk($sformatf("v%0d_z", i), {31'd0, flag_z}, {31'd0, v[i].z});
        chk($sformatf("v%0d_c", i), {31'd0, flag_c}, {31'd0, v[i].c});
        chk($sformatf("v%0d_mem", i), {24'd0, mem[v[i].ca]}, {24'd0, v[i].cm});
        chk($sformatf("v%0d_xfers", i), xfers, v[i].xf);
        chk($sformatf("v%0d_writes", i), wrs, v[i].wr);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("v%0d_halt_idle", i), {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        int cyc;
        // LDA 6, LDB 7, ADD, WRT 8, HLT: 5+3 = 8
        v[0].prog = '{8'h86, 8'h47, 8'h20, 8'hA8, 8'hF0, 8'h00, 8'h05, 8'h03,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v[0].dly = 0; v[0].cyc = 13; v[0].acc = 8'h08; v[0].pc = 4'd5;
        v[0].z = 0; v[0].c = 0; v[0].ca = 4'd8; v[0].cm = 8'h08; v[0].xf = 8; v[0].wr = 1;
        // FF+01 -> 0, Z=C=1; JZ 6 taken, JC 9 taken, WRT 13
        v[1].prog = '{8'h8E, 8'h4F, 8'h20, 8'hB6, 8'hF0, 8'hF0, 8'hC9, 8'hF0,
                      8'hF0, 8'hAD, 8'hF0, 8'h00, 8'h00, 8'h55, 8'hFF, 8'h01};
        v[1].dly = 0; v[1].cyc = 17; v[1].acc = 8'h00; v[1].pc = 4'd11;
        v[1].z = 1; v[1].c = 1; v[1].ca = 4'd13; v[1].cm = 8'h00; v[1].xf = 10; v[1].wr = 1;
        // 02-05 -> FD, C=1 Z=0; JZ not taken
        v[2].prog = '{8'h8E, 8'h4F, 8'h10, 8'hB7, 8'hAC, 8'hF0, 8'h00, 8'hF0,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h02, 8'h05};
        v[2].dly = 0; v[2].cyc = 15; v[2].acc = 8'hFD; v[2].pc = 4'd6;
        v[2].z = 0; v[2].c = 1; v[2].ca = 4'd12; v[2].cm = 8'hFD; v[2].xf = 9; v[2].wr = 1;
        // 04-04 -> 0, Z=1 C=0; JC not taken, JZ 8 taken
        v[3].prog = '{8'h8E, 8'h4F, 8'h10, 8'hC7, 8'hB8, 8'hF0, 8'h00, 8'hF0,
                      8'hAC, 8'hF0, 8'h00, 8'h00, 8'h55, 8'h00, 8'h04, 8'h04};
        v[3].dly = 0; v[3].cyc = 17; v[3].acc = 8'h00; v[3].pc = 4'd10;
        v[3].z = 1; v[3].c = 0; v[3].ca = 4'd12; v[3].cm = 8'h00; v[3].xf = 10; v[3].wr = 1;
        // first program with 3 wait cycles on every transfer
        v[4] = v[0];
        v[4].dly = 3; v[4].cyc = 37;
        // 81+80 -> 01 C=1; later LDA must keep flags
        v[5].prog = '{8'h8E, 8'h4F, 8'h20, 8'h8D, 8'hAC, 8'hF0, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h81, 8'h80};
        v[5].dly = 0; v[5].cyc = 16; v[5].acc = 8'h01; v[5].pc = 4'd6;
        v[5].z = 0; v[5].c = 1; v[5].ca = 4'd12; v[5].cm = 8'h01; v[5].xf = 10; v[5].wr = 1;
        // JZ 3 (no), JMP 14, ADD 0+0 (Z=1), NOP at 15 wraps PC, JZ 3 taken, HLT
        v[6].prog = '{8'hB3, 8'h9E, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
        v[6].dly = 0; v[6].cyc = 12; v[6].acc = 8'h00; v[6].pc = 4'd4;
        v[6].z = 1; v[6].c = 0; v[6].ca = 4'd8; v[6].cm = 8'h00; v[6].xf = 6; v[6].wr = 0;

        reset = 1'b1;
        run   = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", {28'd0, pc_out}, 32'd0);
        chk("rst_acc", {24'd0, acc_out}, 32'd0);
        chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset while a fetch is outstanding and unacked
        for (int k = 0; k < 16; k++) mem[k] = v[1].prog[k];
        dly = 0;
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        dly = 10;
        #1;
        chk("mid_pre_req", {31'd0, mem_req}, 32'd1);
        chk("mid_pre_pc", {28'd0, pc_out}, 32'd3);
        chk("mid_pre_flags", {30'd0, flag_z, flag_c}, 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_req", {31'd0, mem_req}, 32'd0);
        chk("mid_pc", {28'd0, pc_out}, 32'd0);
        chk("mid_acc", {24'd0, acc_out}, 32'd0);
        chk("mid_flags", {30'd0, flag_z, flag_c}, 32'd0);
        chk("mid_halted", {31'd0, halted}, 32'd0);
        chk("mid_no_write", {24'd0, mem[13]}, 32'h55);

        // run dropped during DECODE of LDA: LDA finishes, then idle in FETCH
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        mem[0] = 8'h85; mem[1] = 8'h20; mem[2] = 8'hF0; mem[5] = 8'h2A;
        dly = 0;
        do_reset();
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("gate_req", {31'd0, mem_req}, 32'd0);
        chk("gate_pc", {28'd0, pc_out}, 32'd1);
        chk("gate_xfers", xfers, 2);
        chk("gate_halted", {31'd0, halted}, 32'd0);
        run = 1'b1;
        run_to_halt(cyc);
        chk("gate_done", {31'd0, halted}, 32'd1);
        chk("gate_acc", {24'd0, acc_out}, 32'h2A);
        chk("gate_end_pc", {28'd0, pc_out}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
